// File: rtl/shift_fifo_pkg.sv
// shift_fifo_pkg: FIFO occupancy state encoding and counter width helper.
package shift_fifo_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/shift_fifo_ctrl_if.sv
// shift_fifo_ctrl_if: producer/consumer/bank signals of the shift FIFO controller.
// ovf/udf exist only when SHIFT_FIFO_ERR_FLAGS_EN is defined.
interface shift_fifo_ctrl_if import shift_fifo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int CW = cnt_w(DEPTH);
  logic                   clear;
  logic                   push;
  logic [WIDTH-1:0]       wdata;
  logic                   pop;
  logic [WIDTH-1:0]       rdata;
  logic                   full;
  logic                   empty;
  logic [CW-1:0]          count;
  logic                   bank_push;
  logic [WIDTH-1:0]       bank_data;
  logic [DEPTH*WIDTH-1:0] bank;
`ifdef SHIFT_FIFO_ERR_FLAGS_EN
  logic                   ovf;
  logic                   udf;
  modport master (output clear, push, wdata, pop, bank,
                  input rdata, full, empty, count, bank_push, bank_data, ovf, udf);
  modport slave (input clear, push, wdata, pop, bank,
                 output rdata, full, empty, count, bank_push, bank_data, ovf, udf);
`else
  modport master (output clear, push, wdata, pop, bank,
                  input rdata, full, empty, count, bank_push, bank_data);
  modport slave (input clear, push, wdata, pop, bank,
                 output rdata, full, empty, count, bank_push, bank_data);
`endif
endinterface

// File: rtl/shift_fifo_occ.sv
// shift_fifo_occ: occupancy counter and EMPTY/PARTIAL/FULL state machine.
module shift_fifo_occ import shift_fifo_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_acc,
  input  logic          pop_acc,
  input  logic          clear,
  output logic [CW-1:0] count,
  output fifo_state_t   state
);
  fifo_state_t   state_n;
  logic [CW-1:0] count_n;
  logic          inc, dec;
  assign inc = push_acc & ~pop_acc;
  assign dec = pop_acc & ~push_acc;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_EMPTY;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end
  always_comb begin
    count_n = clear ? '0 : inc ? count + 1'b1 : dec ? count - 1'b1 : count;
    state_n = clear ? ST_EMPTY :
              state == ST_EMPTY   ? (push_acc ? ST_PARTIAL : ST_EMPTY) :
              state == ST_PARTIAL ? ((dec && count == CW'(1)) ? ST_EMPTY :
                                     (inc && count == CW'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL) :
              state == ST_FULL    ? (dec ? ST_PARTIAL : ST_FULL) : ST_EMPTY;
  end
endmodule

// File: rtl/shift_fifo_ctrl.sv
// shift_fifo_ctrl: FIFO sequencing over an external DEPTH x WIDTH shift-register bank.
// Optional sticky ovf/udf flags when SHIFT_FIFO_ERR_FLAGS_EN is defined.
module shift_fifo_ctrl import shift_fifo_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW = cnt_w(DEPTH)
) (
  input logic               clk_i,
  input logic               rst_i,
  shift_fifo_ctrl_if.slave  bus
);
  fifo_state_t   state;
  logic [CW-1:0] count;
  logic          push_acc, pop_acc;
  assign bus.empty     = state == ST_EMPTY;
  assign bus.full      = state == ST_FULL;
  assign pop_acc       = bus.pop & ~bus.clear & ~bus.empty;
  assign push_acc      = bus.push & ~bus.clear & (~bus.full | pop_acc);
  assign bus.bank_push = push_acc;
  assign bus.bank_data = bus.wdata;
  assign bus.count     = count;
  shift_fifo_occ #(.DEPTH(DEPTH)) u_occ (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_acc (push_acc),
    .pop_acc  (pop_acc),
    .clear    (bus.clear),
    .count    (count),
    .state    (state)
  );
  // oldest word sits at bank slot count-1; nothing selected while empty
  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < DEPTH; k++)
      if (count == CW'(k + 1)) bus.rdata = bus.bank[k*WIDTH +: WIDTH];
  end
`ifdef SHIFT_FIFO_ERR_FLAGS_EN
  logic ovf, udf;
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf | (bus.push & bus.full & ~pop_acc);
      udf <= udf | (bus.pop & bus.empty);
    end
  end
  assign bus.ovf = ovf;
  assign bus.udf = udf;
`endif
endmodule
